// File: rtl/display_pkg.sv
// Shared constants and types for the spectrum bar-graph renderer.
// Frame geometry, code widths and the render FSM state encoding.
package display_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int FRAME_PIXELS = 307200;
  localparam int NUM_BINS     = 64;
  localparam int BIN_WIDTH    = 10;
  localparam int ADDR_W       = 19;
  localparam int CODE_W       = 3;
  localparam int HGT_W        = 9;
  localparam int BIN_W        = 6;

  typedef enum logic {
    COLLECT,
    RENDER
  } state_e;

  function automatic logic [HGT_W-1:0] clamp_h(
    input logic [HGT_W-1:0] h,
    input logic [HGT_W-1:0] lim
  );
    return (h > lim) ? lim : h;
  endfunction

endpackage

// File: rtl/spectrum_painter_if.sv
// Valid/ready stream carrying one bar height per beat.
// The producer is the master; the painter is the slave.
interface spectrum_painter_if;
  import display_pkg::*;

  logic             bin_valid;
  logic             bin_ready;
  logic [BIN_W-1:0] bin_index;
  logic [HGT_W-1:0] bin_height;
  logic             bin_last;

  modport master (
    output bin_valid,
    output bin_index,
    output bin_height,
    output bin_last,
    input  bin_ready
  );

  modport slave (
    input  bin_valid,
    input  bin_index,
    input  bin_height,
    input  bin_last,
    output bin_ready
  );

endinterface

// File: rtl/painter_scan_counter.sv
// Raster position tracker: x/y, bin and sub-column, colour and address.
// Position always names the next pixel to be written.
module painter_scan_counter #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BIN_WIDTH = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           adv_i,
  output logic [display_pkg::HGT_W-1:0]  y_o,
  output logic [display_pkg::BIN_W-1:0]  bin_o,
  output logic [display_pkg::CODE_W-1:0] code_o,
  output logic [display_pkg::ADDR_W-1:0] addr_o,
  output logic                           last_pixel_o
);
  import display_pkg::*;

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int SW    = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam int FRAME = H_ACTIVE * V_ACTIVE;

  logic [XW-1:0]     x_q, x_d;
  logic [HGT_W-1:0]  y_q, y_d;
  logic [SW-1:0]     sub_q, sub_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [2:0]        m7_q, m7_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_pixel;

  assign last_pixel = (addr_q == ADDR_W'(FRAME - 1));

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    sub_d  = sub_q;
    bin_d  = bin_q;
    m7_d   = m7_q;
    addr_d = addr_q;
    if (adv_i) begin
      addr_d = last_pixel ? '0 : addr_q + 1'b1;
      if (x_q == XW'(H_ACTIVE - 1)) begin
        x_d   = '0;
        sub_d = '0;
        bin_d = '0;
        m7_d  = '0;
        y_d   = (y_q == HGT_W'(V_ACTIVE - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
        if (sub_q == SW'(BIN_WIDTH - 1)) begin
          sub_d = '0;
          bin_d = bin_q + 1'b1;
          m7_d  = (m7_q == 3'd6) ? 3'd0 : m7_q + 3'd1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      sub_q  <= '0;
      bin_q  <= '0;
      m7_q   <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      sub_q  <= sub_d;
      bin_q  <= bin_d;
      m7_q   <= m7_d;
      addr_q <= addr_d;
    end
  end

  assign y_o          = y_q;
  assign bin_o        = bin_q;
  assign code_o       = CODE_W'(m7_q) + CODE_W'(1);
  assign addr_o       = addr_q;
  assign last_pixel_o = last_pixel;

endmodule

// File: rtl/spectrum_painter.sv
// Collects 64 bar heights, then paints one full frame into the BRAM.
// Sticky ready marks that a complete frame has been written once.
module spectrum_painter #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BIN_WIDTH = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  spectrum_painter_if.slave              bin,
  output logic                           wr_en,
  output logic [display_pkg::ADDR_W-1:0] wr_addr,
  output logic [display_pkg::CODE_W-1:0] wr_data,
  output logic                           ready,
  output logic                           busy
);
  import display_pkg::*;

  state_e            state_q, state_d;
  logic [HGT_W-1:0]  height_q [NUM_BINS];
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CODE_W-1:0] wr_data_q, wr_data_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              bin_ready_q, bin_ready_d;

  logic              accept, emit, lit;
  logic [HGT_W-1:0]  hin, h_cur, thresh;
  logic [HGT_W-1:0]  s_y;
  logic [BIN_W-1:0]  s_bin;
  logic [CODE_W-1:0] s_code;
  logic [ADDR_W-1:0] s_addr;
  logic              s_last;

  painter_scan_counter #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .BIN_WIDTH (BIN_WIDTH)
  ) u_scan (
    .clock        (clock),
    .reset        (reset),
    .adv_i        (emit),
    .y_o          (s_y),
    .bin_o        (s_bin),
    .code_o       (s_code),
    .addr_o       (s_addr),
    .last_pixel_o (s_last)
  );

  assign accept = bin.bin_valid && bin_ready_q;
  assign hin    = clamp_h(bin.bin_height, HGT_W'(V_ACTIVE));

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept && bin.bin_last) begin
          state_d = RENDER;
          emit    = 1'b1;
        end
      end
      RENDER: begin
        emit = 1'b1;
        if (s_last) state_d = COLLECT;
      end
    endcase
  end

  // Pixel 0 is painted on the same edge that stores the last beat.
  always_comb begin
    h_cur = height_q[s_bin];
    if (accept && (bin.bin_index == s_bin)) h_cur = hin;
    thresh = HGT_W'(V_ACTIVE) - h_cur;
    lit    = (s_y >= thresh);
  end

  always_comb begin
    wr_en_d     = emit;
    wr_addr_d   = emit ? s_addr : '0;
    wr_data_d   = (emit && lit) ? s_code : '0;
    busy_d      = emit;
    bin_ready_d = !emit;
    ready_d     = ready_q || (wr_en_q && !emit);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BINS; i++) height_q[i] <= '0;
    end else if (accept) begin
      height_q[bin.bin_index] <= hin;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      bin_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      bin_ready_q <= bin_ready_d;
    end
  end

  assign bin.bin_ready = bin_ready_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign ready         = ready_q;
  assign busy          = busy_q;

endmodule
